universal_shift_register_seq: RTL and testbench
===============================================

# universal_shift_register_seq

Parametrised universal shift register with a multi-step shift sequencer. It keeps the hold / shift-right / shift-left / parallel-load mode set of the existing 4- and 8-bit shift registers, generalised to WIDTH bits. It adds a `start`/`count` request that runs N shift steps autonomously with `busy`/`done` status. It sits in the datapath as the shifter and serialiser feeding the ALU and I/O paths.

## Interface
- `WIDTH`, 8: register width in bits, ≥2.
- `CW`, `$clog2(WIDTH)+1`: width of the `count` input.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enb`  in  1  global enable; when 0, all state is frozen.
- `c1`, `c0`  in  1 each  mode select: 00 hold, 01 shift right, 10 shift left, 11 load.
- `start`  in  1  request a sequenced shift of `count` steps.
- `count`  in  CW  number of shift steps; sampled with `start`.
- `par_in`  in  WIDTH  parallel load data.
- `sli`  in  1  serial input entering bit 0 on shift left.
- `sri`  in  1  serial input entering bit WIDTH-1 on shift right.
- `rot`  in  1  rotate select; the port exists only with `USR_ROTATE_EN`.
- `par_out`  out  WIDTH  register contents.
- `sor`  out  1  `par_out[0]`, the bit leaving on the next right shift.
- `sol`  out  1  `par_out[WIDTH-1]`, the bit leaving on the next left shift.
- `busy`  out  1  sequenced shift in progress.
- `done`  out  1  one-cycle pulse on sequence completion.

## Operation
- Reset values: `par_out`=0, `busy`=0, `done`=0, state IDLE, internal counter 0.
- Shift right: `par_out <= {sri, par_out[WIDTH-1:1]}`.
- Shift left: `par_out <= {par_out[WIDTH-2:0], sli}`.
- Load: `par_out <= par_in`.
- Hold: no change.
- State IDLE, `enb`=1, `start`=0: the selected mode is applied on every rising edge (continuous legacy behaviour).
- State IDLE, `enb`=1, `start`=1, mode 01 or 10, `count`>0:
  - Latch the direction and `count` into the counter; go to RUN.
  - No shift occurs on this edge.
- State IDLE, `enb`=1, `start`=1, mode 01 or 10, `count`=0:
  - No shift; stay in IDLE.
  - `done` pulses for one cycle; `busy` never rises.
- `start`=1 with mode 00 or 11: `start` is ignored and the mode is applied normally.
- State RUN, `enb`=1:
  - One shift per edge in the latched direction; the counter decrements.
  - On the edge where the counter goes 1→0: return to IDLE and pulse `done`.
- State RUN: `c1`, `c0`, `start` and `count` are ignored. `sli` and `sri` are still sampled live on each step.
- `count` is not saturated: counts above WIDTH shift the serial input through repeatedly.
- `enb`=0 in any state: `par_out`, the counter and the state are frozen, and `busy` holds its value. `done` still clears after one cycle.
- `rst_n` asserted mid-run: all outputs take their reset values immediately and the sequence is aborted without a `done`.

## Timing
- Single-step modes: `par_out` updates on the edge after the mode is sampled (latency 1).
- Sequenced shift of N>0 steps, with `start` sampled at edge k and `enb` held at 1:
  - `busy`=1 from edge k to edge k+N.
  - Shifts occur at edges k+1 … k+N.
  - `done`=1 from edge k+N to edge k+N+1.
  - Total of N+1 cycles from the request to `done`.
- Each cycle with `enb`=0 during RUN delays `done` by one cycle.
- `busy` and `done` are never high in the same cycle.
- A new `start` is accepted on the edge where `done` is high.

## Configuration
- `USR_ROTATE_EN` defined:
  - `rot` port present.
  - `rot`=1 replaces `sri` with `par_out[0]` on right shifts and `sli` with `par_out[WIDTH-1]` on left shifts, in both single-step and sequenced modes.
  - In RUN, `rot` is sampled with `start` and latched for the whole sequence.
- `USR_ROTATE_EN` undefined: no `rot` port; shifts are always logical with `sli`/`sri` as serial inputs.

## Test plan
- Reset and load (WIDTH=8): `rst_n`=0 → `par_out`=0x00, `busy`=0, `done`=0. Then mode 11 with `par_in`=0x54 → `par_out`=0x54 after one edge.
- Sequenced right shift: from 0x54 with `sri`=1, `start` + mode 01 + `count`=3 → `par_out` steps 0xAA, 0xD5, 0xEA. `busy` high for 3 cycles; `done` high for one cycle after the third shift.
- Sequenced left shift with stall: from 0x54 with `sli`=0, `count`=2, `enb` dropped for 2 cycles after the first shift → `par_out` 0xA8 then 0x50. `done` arrives 2 cycles late; `par_out` holds 0xA8 during the stall.
- Edge requests:
  - `count`=0 → `done` pulses next cycle, `par_out` unchanged, `busy`=0.
  - `start` with mode 11 → plain load, no `done`.
- Reset mid-run: `rst_n` low during a `count`=5 sequence → immediate 0x00, `busy`=0, no `done`. After release, the register is idle and accepts a new `start`.
- Rotate (`USR_ROTATE_EN` defined): from 0x81 with `rot`=1, mode 01, `count`=1 → 0xC0. With `count`=8 → returns to 0x81, `done` after 8 shifts.

Source files
------------

// File: rtl/universal_shift_register_seq.sv
// universal_shift_register_seq: WIDTH-bit hold/shift/load register with an N-step shift sequencer.
// Optional feature macro: USR_ROTATE_EN adds the rot_i port for rotate instead of logical shifts.
module universal_shift_register_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enb_i,
    input  logic             c1_i,
    input  logic             c0_i,
    input  logic             start_i,
    input  logic [CW-1:0]    count_i,
    input  logic [WIDTH-1:0] par_in_i,
    input  logic             sli_i,
    input  logic             sri_i,
`ifdef USR_ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] par_out_o,
    output logic             sor_o,
    output logic             sol_o,
    output logic             busy_o,
    output logic             done_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             rot_cur;
    logic             seq_req;
    logic [WIDTH-1:0] shr, shl;

    assign seq_req = start_i && (c1_i ^ c0_i);

`ifdef USR_ROTATE_EN
    logic rot_q;
    assign rot_cur = (state_q == RUN) ? rot_q : rot_i;
    // rotate select is captured with an accepted sequence and held for its whole run
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rot_q <= 1'b0;
        else if (enb_i && state_q == IDLE && seq_req) rot_q <= rot_i;
    end
`else
    assign rot_cur = 1'b0;
`endif

    assign shr = {rot_cur ? data_q[0] : sri_i, data_q[WIDTH-1:1]};
    assign shl = {data_q[WIDTH-2:0], rot_cur ? data_q[WIDTH-1] : sli_i};

    // next state: legacy single-step modes in IDLE, autonomous counted shifts in RUN
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (enb_i) begin
            if (state_q == RUN) begin
                data_d = dir_q ? shl : shr;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (seq_req) begin
                if (count_i == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_d   = count_i;
                    dir_d   = c1_i;
                end
            end else begin
                data_d = c1_i ? (c0_i ? par_in_i : shl) : (c0_i ? shr : data_q);
            end
        end
    end

    // state registers; done is not gated by enable so its pulse always clears
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign par_out_o = data_q;
    assign sor_o     = data_q[0];
    assign sol_o     = data_q[WIDTH-1];
    assign busy_o    = (state_q == RUN);
    assign done_o    = done_q;
endmodule

// File: tb/tb_universal_shift_register_seq.sv
// tb_universal_shift_register_seq: directed test with a step-counting reference model.
module tb_universal_shift_register_seq;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;
`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 0, rst_n = 0, enb = 1, c1 = 0, c0 = 0, start = 0, sli = 0, sri = 0, rot = 0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  par_in = '0;
    logic [W-1:0]  par_out;
    logic          sor, sol, busy, done;
    int checks = 0, failures = 0;

    universal_shift_register_seq #(.WIDTH(W), .CW(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enb_i(enb), .c1_i(c1), .c0_i(c0),
        .start_i(start), .count_i(count), .par_in_i(par_in), .sli_i(sli), .sri_i(sri),
`ifdef USR_ROTATE_EN
        .rot_i(rot),
`endif
        .par_out_o(par_out), .sor_o(sor), .sol_o(sol), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: register value plus number of sequenced steps still owed
    logic [W-1:0] m_data;
    int           m_rem;
    bit           m_left, m_rot, m_done;

    function automatic logic [W-1:0] shift_once(input logic [W-1:0] d, input bit left, input bit r);
        logic [W-1:0] res;
        if (left) res = (d << 1) | W'(r ? d[W-1] : sli);
        else      res = (d >> 1) | ((r ? d[0] : sri) ? W'(1) << (W - 1) : W'(0));
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0; m_rem <= 0; m_done <= 0; m_left <= 0; m_rot <= 0;
        end else begin
            m_done <= 0;
            if (enb) begin
                if (m_rem > 0) begin
                    m_data <= shift_once(m_data, m_left, m_rot);
                    m_rem  <= m_rem - 1;
                    if (m_rem == 1) m_done <= 1;
                end else if (start && (c1 != c0)) begin
                    if (count == 0) m_done <= 1;
                    else begin
                        m_rem <= int'(count); m_left <= c1; m_rot <= ROT_EN && rot;
                    end
                end else if (c1 && c0) m_data <= par_in;
                else if (c1 || c0)     m_data <= shift_once(m_data, c1, ROT_EN && rot);
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("par_out", par_out, m_data);
        chk("sor", sor, m_data[0]);
        chk("sol", sol, m_data[W-1]);
        chk("busy", busy, m_rem > 0);
        chk("done", done, m_done);
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lit(input string name, input logic [W-1:0] p, input logic b, input logic d);
        chk({name, ".par_out"}, par_out, p);
        chk({name, ".busy"}, busy, b);
        chk({name, ".done"}, done, d);
    endtask

    task automatic set_mode(input logic [1:0] m);
        {c1, c0} = m;
    endtask

    initial begin
        step(2);
        lit("reset", 8'h00, 0, 0);
        rst_n = 1;
        set_mode(2'b11); par_in = 8'h54; step();
        lit("load", 8'h54, 0, 0);

        // sequenced right shift, count 3; mode/par_in changes are ignored while running
        sri = 1; set_mode(2'b01); count = 3; start = 1; step();
        lit("sr_k", 8'h54, 1, 0);
        start = 0; set_mode(2'b11); par_in = 8'hFF; step();
        lit("sr_1", 8'hAA, 1, 0);
        step(); lit("sr_2", 8'hD5, 1, 0);
        step(); lit("sr_3", 8'hEA, 0, 1);
        set_mode(2'b00); step();
        lit("sr_end", 8'hEA, 0, 0);

        // sequenced left shift with a two-cycle stall
        set_mode(2'b11); par_in = 8'h54; step();
        sli = 0; set_mode(2'b10); count = 2; start = 1; step();
        lit("sl_k", 8'h54, 1, 0);
        start = 0; set_mode(2'b00); step();
        lit("sl_1", 8'hA8, 1, 0);
        enb = 0; step(); lit("sl_st1", 8'hA8, 1, 0);
        step(); lit("sl_st2", 8'hA8, 1, 0);
        enb = 1; step(); lit("sl_2", 8'h50, 0, 1);
        step(); lit("sl_end", 8'h50, 0, 0);

        // count of zero: immediate done pulse, no busy
        set_mode(2'b01); count = 0; start = 1; step();
        lit("cnt0", 8'h50, 0, 1);
        start = 0; set_mode(2'b00); step();
        lit("cnt0_end", 8'h50, 0, 0);

        // start with load mode is a plain load
        set_mode(2'b11); par_in = 8'h3C; count = 4; start = 1; step();
        lit("st_load", 8'h3C, 0, 0);
        start = 0; set_mode(2'b00); step();
        lit("st_load2", 8'h3C, 0, 0);

        // reset during a five-step run
        sri = 0; set_mode(2'b01); count = 5; start = 1; step();
        start = 0; set_mode(2'b00); step(2);
        lit("rst_run", 8'h0F, 1, 0);
        rst_n = 0; #1;
        lit("rst_now", 8'h00, 0, 0);
        step(2);
        lit("rst_hold", 8'h00, 0, 0);
        rst_n = 1;
        set_mode(2'b11); par_in = 8'h81; step();
        set_mode(2'b01); count = 1; start = 1; step();
        lit("post_k", 8'h81, 1, 0);
        start = 0; set_mode(2'b00); step();
        lit("post_1", 8'h40, 0, 1);

`ifdef USR_ROTATE_EN
        set_mode(2'b11); par_in = 8'h81; step();
        rot = 1; set_mode(2'b01); count = 1; start = 1; step();
        start = 0; set_mode(2'b00); step();
        lit("rot1", 8'hC0, 0, 1);
        set_mode(2'b11); par_in = 8'h81; step();
        set_mode(2'b01); count = 8; start = 1; step();
        start = 0; rot = 0; set_mode(2'b00); step(7);
        lit("rot8_7", 8'h03, 1, 0);
        step(); lit("rot8", 8'h81, 0, 1);
`endif
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
